rat_regfile: RTL

RAT_REGFILE -- requirements
Module: rat_regfile

---
 rtl/rat_regfile_pkg.sv | 9 +
 rtl/rat_ckpt_fifo.sv | 110 +++++++++++
 rtl/rat_regfile.sv | 139 +++++++++++++
 3 files changed

// File: rtl/rat_regfile_pkg.sv
// Shared default widths for the register alias table and its checkpoint FIFO.
// Consumers derive every other width from these values.
package rat_regfile_pkg;
  localparam int NUM_REGS_DEF  = 32;
  localparam int XLEN_DEF      = 32;
  localparam int ROB_WIDTH_BIT = 4;
  localparam int NUM_RD_DEF    = 2;
  localparam int NUM_CKPT_DEF  = 4;
endpackage

// File: rtl/rat_ckpt_fifo.sv
// Circular FIFO of busy/tag snapshots used to roll the alias table back on a
// branch mispredict. Saved snapshots also see commit clears while they are live.
module rat_ckpt_fifo
  import rat_regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int REG_W    = $clog2(NUM_REGS),
  parameter int ROB_W    = ROB_WIDTH_BIT,
  parameter int NUM_CKPT = NUM_CKPT_DEF,
  parameter int CKPT_W   = $clog2(NUM_CKPT)
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           rdy_in,
  input  logic                           clear_flag,
  input  logic                           take,
  input  logic                           rel,
  input  logic                           restore,
  input  logic [CKPT_W-1:0]              restore_id,
  input  logic [NUM_REGS-1:0]            take_busy,
  input  logic [NUM_REGS-1:0][ROB_W-1:0] take_qi,
  input  logic                           commit_en,
  input  logic [REG_W-1:0]               commit_reg,
  input  logic [ROB_W-1:0]               commit_rob,
  output logic [CKPT_W-1:0]              tail,
  output logic                           full,
  output logic                           empty,
  output logic [NUM_REGS-1:0]            restore_busy,
  output logic [NUM_REGS-1:0][ROB_W-1:0] restore_qi
);

  logic [CKPT_W-1:0]              head_reg, head_next;
  logic [CKPT_W-1:0]              tail_reg, tail_next;
  logic [CKPT_W:0]                count_reg, count_next;
  logic [NUM_REGS-1:0]            slot_busy [NUM_CKPT];
  logic [NUM_REGS-1:0][ROB_W-1:0] slot_qi   [NUM_CKPT];
  logic [NUM_CKPT-1:0]            slot_valid;
  logic [CKPT_W-1:0]              restore_dist;
  logic                           rel_ok;
  logic                           take_ok;

  assign full         = count_reg == (CKPT_W+1)'(NUM_CKPT);
  assign empty        = count_reg == '0;
  assign tail         = tail_reg;
  assign rel_ok       = rel && !empty;
  // A release in the same cycle frees the head slot, so a take may reuse it.
  assign take_ok      = take && !restore && (!full || rel_ok);
  assign restore_dist = restore_id - head_reg;
  assign restore_busy = slot_busy[restore_id];
  assign restore_qi   = slot_qi[restore_id];

  generate
    for (genvar gi = 0; gi < NUM_CKPT; gi++) begin : g_valid
      logic [CKPT_W-1:0] offset;
      assign offset         = CKPT_W'(gi) - head_reg;
      assign slot_valid[gi] = {1'b0, offset} < count_reg;
    end
  endgenerate

  always_comb begin
    head_next  = head_reg + CKPT_W'(rel_ok);
    tail_next  = tail_reg + CKPT_W'(take_ok);
    count_next = count_reg + (CKPT_W+1)'(take_ok) - (CKPT_W+1)'(rel_ok);
    if (restore) begin
      tail_next  = restore_id + CKPT_W'(1);
      count_next = {1'b0, restore_dist} + (CKPT_W+1)'(1) - (CKPT_W+1)'(rel_ok);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (rdy_in) begin
      if (clear_flag) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        head_reg  <= head_next;
        tail_reg  <= tail_next;
        count_reg <= count_next;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_CKPT; i++) begin
        slot_busy[i] <= '0;
        slot_qi[i]   <= '0;
      end
    end else if (rdy_in) begin
      for (int i = 0; i < NUM_CKPT; i++) begin
        if (clear_flag) begin
          slot_busy[i] <= '0;
          slot_qi[i]   <= '0;
        end else if (take_ok && tail_reg == CKPT_W'(i)) begin
          slot_busy[i] <= take_busy;
          slot_qi[i]   <= take_qi;
        end else if (commit_en && slot_valid[i] && slot_qi[i][commit_reg] == commit_rob) begin
          slot_busy[i][commit_reg] <= 1'b0;
          slot_qi[i][commit_reg]   <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/rat_regfile.sv
// Architectural register file with rename alias table (busy + producing ROB tag),
// combinational operand lookup with ROB bypass, and checkpoint/restore support.
module rat_regfile
  import rat_regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int REG_W    = $clog2(NUM_REGS),
  parameter int XLEN     = XLEN_DEF,
  parameter int ROB_W    = ROB_WIDTH_BIT,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int NUM_CKPT = NUM_CKPT_DEF,
  parameter int CKPT_W   = $clog2(NUM_CKPT)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    clear_flag,
  input  logic [NUM_RD*REG_W-1:0] rd_reg_id,
  output logic [NUM_RD*XLEN-1:0]  rd_val,
  output logic [NUM_RD-1:0]       rd_dep,
  output logic [NUM_RD*ROB_W-1:0] rd_rob_id,
  output logic [NUM_RD*ROB_W-1:0] rob_query_id,
  input  logic [NUM_RD-1:0]       rob_query_ready,
  input  logic [NUM_RD*XLEN-1:0]  rob_query_val,
  input  logic [REG_W-1:0]        new_reg_id,
  input  logic [ROB_W-1:0]        new_rob_id,
  input  logic [REG_W-1:0]        write_reg_id,
  input  logic [ROB_W-1:0]        write_rob_id,
  input  logic [XLEN-1:0]         write_val,
  input  logic                    ckpt_take,
  output logic [CKPT_W-1:0]       ckpt_id,
  output logic                    ckpt_full,
  output logic                    ckpt_empty,
  input  logic                    ckpt_release,
  input  logic                    ckpt_restore,
  input  logic [CKPT_W-1:0]       ckpt_restore_id
);

  logic [XLEN-1:0]                regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0]            busy_reg, busy_next, busy_restored;
  logic [NUM_REGS-1:0][ROB_W-1:0] qi_reg, qi_next, qi_restored;
  logic [NUM_REGS-1:0]            slot_busy;
  logic [NUM_REGS-1:0][ROB_W-1:0] slot_qi;
  logic                           commit_en;
  logic                           rename_en;

  assign commit_en = write_reg_id != '0;
  assign rename_en = new_reg_id != '0;

  // Rename is applied after the commit clear so it wins on the same register.
  always_comb begin
    busy_next = busy_reg;
    qi_next   = qi_reg;
    if (commit_en && qi_reg[write_reg_id] == write_rob_id && write_reg_id != new_reg_id) begin
      busy_next[write_reg_id] = 1'b0;
      qi_next[write_reg_id]   = '0;
    end
    if (rename_en) begin
      busy_next[new_reg_id] = 1'b1;
      qi_next[new_reg_id]   = new_rob_id;
    end
  end

  always_comb begin
    busy_restored = slot_busy;
    qi_restored   = slot_qi;
    if (commit_en && slot_qi[write_reg_id] == write_rob_id) begin
      busy_restored[write_reg_id] = 1'b0;
      qi_restored[write_reg_id]   = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= '0;
      busy_reg <= '0;
      qi_reg   <= '0;
    end else if (rdy_in) begin
      if (commit_en) regs_reg[write_reg_id] <= write_val;
      if (clear_flag) begin
        busy_reg <= '0;
        qi_reg   <= '0;
      end else if (ckpt_restore) begin
        busy_reg <= busy_restored;
        qi_reg   <= qi_restored;
      end else begin
        busy_reg <= busy_next;
        qi_reg   <= qi_next;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_lookup
      logic [REG_W-1:0] idx;
      logic             fwd;
      logic             busy;
      logic [ROB_W-1:0] tag;
      assign idx  = rd_reg_id[gi*REG_W +: REG_W];
      assign fwd  = rename_en && idx == new_reg_id;
      assign busy = busy_reg[idx] || fwd;
      assign tag  = fwd ? new_rob_id : qi_reg[idx];
      assign rd_rob_id[gi*ROB_W +: ROB_W] = (idx == '0) ? '0 : tag;
      assign rd_dep[gi] = (idx != '0) && busy && !rob_query_ready[gi];
      assign rd_val[gi*XLEN +: XLEN] = (idx == '0) ? '0 :
                                       busy ? rob_query_val[gi*XLEN +: XLEN] : regs_reg[idx];
    end
  endgenerate

  assign rob_query_id = rd_rob_id;

  rat_ckpt_fifo #(
    .NUM_REGS (NUM_REGS),
    .REG_W    (REG_W),
    .ROB_W    (ROB_W),
    .NUM_CKPT (NUM_CKPT),
    .CKPT_W   (CKPT_W)
  ) u_ckpt (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .clear_flag   (clear_flag),
    .take         (ckpt_take),
    .rel          (ckpt_release),
    .restore      (ckpt_restore),
    .restore_id   (ckpt_restore_id),
    .take_busy    (busy_next),
    .take_qi      (qi_next),
    .commit_en    (commit_en),
    .commit_reg   (write_reg_id),
    .commit_rob   (write_rob_id),
    .tail         (ckpt_id),
    .full         (ckpt_full),
    .empty        (ckpt_empty),
    .restore_busy (slot_busy),
    .restore_qi   (slot_qi)
  );

endmodule
